// File: rtl/nn_mac_sequencer.sv
// Control sequencer feeding a fixed-point neuron MAC: buffers one activation
// vector, then walks N_OUT neurons through bias load, N_IN accumulates and
// result capture with a valid/ready output. Define NN_SEQ_RELU_EN for fused ReLU.
module nn_mac_sequencer #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2,
  parameter int W_AW  = 3,
  parameter int B_AW  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_data,
  output logic [W_AW-1:0]   w_addr,
  input  logic [15:0]       w_rdata,
  output logic [B_AW-1:0]   b_addr,
  input  logic [31:0]       b_rdata,
  output logic [3:0]        mac_ctrl,
  output logic [15:0]       mac_in,
  output logic [15:0]       mac_w,
  output logic [31:0]       mac_bias,
  input  logic [15:0]       mac_zout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_data,
  output logic [B_AW-1:0]   out_idx,
  output logic              layer_done
);

  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_LOADB, S_ACC, S_HOLD, S_OUT} state_t;

  state_t             r_state, w_next;
  logic [IW-1:0]      r_k, r_i;
  logic [B_AW-1:0]    r_j;
  logic signed [15:0] r_buf [N_IN];
  logic               w_in_acc, w_out_acc, w_last_k, w_last_i, w_last_j;
  int                 w_off;

  function automatic logic [15:0] capture(input logic [15:0] z);
`ifdef NN_SEQ_RELU_EN
    return z[15] ? 16'd0 : z;
`else
    return z;
`endif
  endfunction

  assign out_valid = (r_state == S_OUT);
  assign w_in_acc  = in_valid && (r_state == S_IDLE);
  assign w_out_acc = out_valid && out_ready;
  assign w_last_k  = (r_k == IW'(N_IN - 1));
  assign w_last_i  = (r_i == IW'(N_IN - 1));
  assign w_last_j  = (r_j == B_AW'(N_OUT - 1));

  // ROM reads are registered, so addresses run one cycle ahead of their use
  assign b_addr   = r_j;
  assign w_addr   = W_AW'(int'(r_j) * N_IN + w_off);
  assign mac_w    = w_rdata;
  assign mac_bias = b_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    mac_ctrl = 4'b0000;
    mac_in   = 16'd0;
    w_off    = 0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        mac_ctrl = 4'b1111;
        if (w_in_acc && w_last_k) w_next = S_PREP;
      end
      S_PREP: begin
        mac_ctrl = 4'b1111;
        w_next   = S_LOADB;
      end
      S_LOADB: begin
        mac_ctrl = 4'b1111;
        w_next   = S_ACC;
      end
      S_ACC: begin
        mac_in = r_buf[r_i];
        w_off  = int'(r_i) + 1;
        if (w_last_i) w_next = S_HOLD;
      end
      S_HOLD: w_next = S_OUT;
      // MAC has no enable: zero input with ctrl=0000 keeps its sum frozen
      S_OUT: begin
        if (out_ready) w_next = w_last_j ? S_IDLE : S_PREP;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_k        <= '0;
      r_i        <= '0;
      r_j        <= '0;
      out_data   <= 16'd0;
      out_idx    <= '0;
      layer_done <= 1'b0;
    end else begin
      layer_done <= w_out_acc && w_last_j;
      if (w_in_acc)
        r_k <= w_last_k ? '0 : r_k + 1'b1;
      if (r_state == S_ACC)
        r_i <= w_last_i ? '0 : r_i + 1'b1;
      if (w_out_acc)
        r_j <= w_last_j ? '0 : r_j + 1'b1;
      if (r_state == S_HOLD) begin
        out_data <= capture(mac_zout);
        out_idx  <= r_j;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_acc) r_buf[r_k] <= signed'(in_data);
  end

endmodule

// File: tb/tb_nn_mac_sequencer.sv
// Self-checking bench for nn_mac_sequencer with behavioural ROMs, a MAC model
// and a per-neuron dot-product reference computed from the stored vector.
module tb_nn_mac_sequencer;
  localparam int N_IN  = 4;
  localparam int N_OUT = 2;
  localparam int W_AW  = 3;
  localparam int B_AW  = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready;
  logic [15:0]       in_data;
  logic [W_AW-1:0]   w_addr;
  logic [15:0]       w_rdata;
  logic [B_AW-1:0]   b_addr;
  logic [31:0]       b_rdata;
  logic [3:0]        mac_ctrl;
  logic [15:0]       mac_in, mac_w;
  logic [31:0]       mac_bias;
  logic [15:0]       mac_zout;
  logic              out_valid, out_ready;
  logic [15:0]       out_data;
  logic [B_AW-1:0]   out_idx;
  logic              layer_done;

  nn_mac_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .W_AW(W_AW), .B_AW(B_AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_addr(w_addr), .w_rdata(w_rdata), .b_addr(b_addr), .b_rdata(b_rdata),
    .mac_ctrl(mac_ctrl), .mac_in(mac_in), .mac_w(mac_w), .mac_bias(mac_bias),
    .mac_zout(mac_zout), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .layer_done(layer_done)
  );

  always #5 clk = ~clk;

  logic signed [15:0] wrom [2**W_AW];
  logic signed [31:0] brom [2**B_AW];
  logic signed [15:0] vec  [N_IN];
  logic        [15:0] res  [N_OUT];
  logic signed [31:0] z;
  int n_checks = 0;
  int n_errs   = 0;
  int ld_seen  = 0;
  int ld_exp   = 0;

  always @(posedge clk) begin
    w_rdata <= wrom[w_addr];
    b_rdata <= brom[b_addr];
    if (mac_ctrl == 4'b1111) z <= signed'(mac_bias);
    else z <= z + 32'(signed'(mac_w)) * 32'(signed'(mac_in));
    if (layer_done) ld_seen++;
  end
  assign mac_zout = z[25:10];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_neuron(input int j);
    logic signed [31:0] acc;
    acc = brom[j];
    for (int i = 0; i < N_IN; i++)
      acc = acc + 32'(vec[i]) * 32'(wrom[j*N_IN+i]);
`ifdef NN_SEQ_RELU_EN
    if (acc[25]) return 16'd0;
`endif
    return acc[25:10];
  endfunction

  task automatic rand_all();
    for (int i = 0; i < 2**W_AW; i++) wrom[i] = 16'($urandom);
    for (int i = 0; i < 2**B_AW; i++) brom[i] = $urandom;
    for (int i = 0; i < N_IN; i++)   vec[i]  = 16'($urandom);
  endtask

  task automatic feed();
    for (int k = 0; k < N_IN; k++) begin
      int t = 0;
      in_valid = 1'b1;
      in_data  = vec[k];
      while (!in_ready && t < 100) begin tick(); t++; end
      if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
      tick();
    end
  endtask

  task automatic wait_out(input bit gate, input int j);
    int cnt = 0;
    while (!out_valid && cnt < 100) begin
      tick();
      cnt++;
      if (gate) chk("gate_in_ready", 32'(in_ready), 32'd0);
    end
    chk("latency", cnt, N_IN + 3);
    chk("out_data", 32'(out_data), 32'(ref_neuron(j)));
    chk("out_idx", 32'(out_idx), 32'(j));
    res[j] = out_data;
  endtask

  task automatic run_layer(input int stall, input bit gate);
    feed();
    in_valid = gate;
    in_data  = 16'($urandom);
    for (int j = 0; j < N_OUT; j++) begin
      wait_out(gate, j);
      if (j == 0) begin
        for (int s = 0; s < stall; s++) begin
          tick();
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_data", 32'(out_data), 32'(res[0]));
          chk("stall_mac_in", 32'(mac_in), 32'd0);
        end
      end
      out_ready = 1'b1;
      if (j == N_OUT - 1) in_valid = 1'b0;
      tick();
      out_ready = 1'b0;
      chk("layer_done", 32'(layer_done), (j == N_OUT - 1) ? 32'd1 : 32'd0);
    end
    ld_exp++;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    rand_all();
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mac_ctrl", 32'(mac_ctrl), 32'hF);
    chk("rst_mac_in", 32'(mac_in), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_layer_done", 32'(layer_done), 32'd0);
    chk("rst_w_addr", 32'(w_addr), 32'd0);
    chk("rst_b_addr", 32'(b_addr), 32'd0);
    rst = 1'b1;
    tick();

    // basic
    for (int i = 0; i < N_IN; i++) vec[i] = 16'sd1024;
    for (int i = 0; i < 2**W_AW; i++) wrom[i] = 16'sd1024;
    brom[0] = 32'sd0; brom[1] = 32'sd1048576;
    run_layer(0, 0);
    chk("basic_n0", 32'(res[0]), 32'd4096);
    chk("basic_n1", 32'(res[1]), 32'd5120);

    // signs
    vec[0] = 16'sd1024; vec[1] = -16'sd2048; vec[2] = 16'sd512; vec[3] = 16'sd0;
    wrom[0] = 16'sd1024; wrom[1] = 16'sd1024; wrom[2] = -16'sd2048; wrom[3] = 16'sd3000;
    brom[0] = 32'sd0;
    run_layer(0, 0);
`ifdef NN_SEQ_RELU_EN
    chk("signs_n0", 32'(res[0]), 32'd0);
`else
    chk("signs_n0", 32'(res[0]), 32'(16'hF800));
`endif

    // backpressure, then input gating
    rand_all();
    run_layer(20, 0);
    rand_all();
    run_layer(0, 1);

    // reset during accumulation of neuron 1
    rand_all();
    feed();
    in_valid = 1'b0;
    wait_out(0, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_ctrl", 32'(mac_ctrl), 32'h0);
    rst = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_mac_ctrl", 32'(mac_ctrl), 32'hF);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("rst_next_in_ready", 32'(in_ready), 32'd1);
    chk("rst_next_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b1;
    tick();
    rand_all();
    run_layer(0, 0);

    // back-to-back layers, then a few random ones
    for (int n = 0; n < 6; n++) begin
      rand_all();
      run_layer((n % 3 == 2) ? int'($urandom_range(1, 5)) : 0, n[0]);
    end

    tick(); tick();
    chk("layer_done_count", ld_seen, ld_exp);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 expected=0");
    $fatal(1, "timeout");
  end
endmodule
